// File: rtl/alu_pkg.sv
// Shared definitions for the ALU back end: opcode encodings, the legality test,
// and the write-back entry carried from execute to the register file.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int RA_W   = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_MOD = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_CAT = 4'b0101;
  localparam logic [3:0] OP_EQ  = 4'b0110;
  localparam logic [3:0] OP_GT  = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic [RA_W-1:0]   rd;
  } wb_entry_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_SLL;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending write-back entries. The whole array and an
// occupancy mask are exposed so the parent can search it for forwarding.
module wb_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output wb_entry_t       entries [DEPTH],
  output logic [DEPTH-1:0] valid_mask,
  output logic [PW-1:0]   rd_ptr,
  output logic [PW:0]     count
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  // Storage carries no reset; occupancy is defined solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]    = mem[i];
      valid_mask[i] = {1'b0, PW'(i) - rd_ptr} < count;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_writeback_stage.sv
// Write-back stage behind the execute ALU: buffers results, commits them to the
// register file, maintains architectural flags and serves forwarding lookups.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter  int N     = 32,
  parameter  int DEPTH = 4,
  parameter  int RA    = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [N-1:0]  in_result,
  input  logic          in_carry,
  input  logic [RA-1:0] in_rd,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [RA-1:0] wb_addr,
  output logic [N-1:0]  wb_data,
  input  logic [RA-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [N-1:0]  fwd_data,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_cmp,
  output logic [PW:0]   count,
  output logic [7:0]    illegal_cnt
);

  wb_entry_t        push_entry;
  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid_mask;
  logic [PW-1:0]    rd_ptr;
  logic             accept, push, pop;
  logic [RA-1:0]    last_addr_p1;
  logic [N-1:0]     last_data_p1;

  assign in_ready = count < (PW+1)'(DEPTH);
  assign wb_valid = count != '0;
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_legal_op(in_opcode);
  assign pop      = wb_valid && wb_ready;

  assign push_entry = '{opcode: in_opcode, result: in_result, carry: in_carry, rd: in_rd};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .valid_mask (valid_mask),
    .rd_ptr     (rd_ptr),
    .count      (count)
  );

  // While empty the port repeats the last committed write (zero after reset).
  assign wb_addr = wb_valid ? head.rd     : last_addr_p1;
  assign wb_data = wb_valid ? head.result : last_data_p1;

  // Commit stage: flags and held write-port values update on the popping edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      flag_cmp     <= 1'b0;
      last_addr_p1 <= '0;
      last_data_p1 <= '0;
    end else if (pop) begin
      flag_z       <= head.result == '0;
      last_addr_p1 <= head.rd;
      last_data_p1 <= head.result;
      if (head.opcode == OP_ADD) flag_c <= head.carry;
      if (head.opcode == OP_EQ || head.opcode == OP_GT) flag_cmp <= head.result[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && !is_legal_op(in_opcode) && illegal_cnt != 8'hFF) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  // Walk from oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      idx = rd_ptr + PW'(a);
      if (valid_mask[idx] && entries[idx].rd == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].result;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage with hand-computed expectations.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [31:0] in_result;
  logic        in_carry;
  logic [3:0]  in_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        flag_z, flag_c, flag_cmp;
  logic [2:0]  count;
  logic [7:0]  illegal_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  alu_writeback_stage #(.N(32), .DEPTH(4), .RA(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_result(in_result), .in_carry(in_carry), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .flag_z(flag_z), .flag_c(flag_c), .flag_cmp(flag_cmp),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic c, input logic [3:0] rd);
    in_valid  = 1'b1;
    in_opcode = op;
    in_result = res;
    in_carry  = c;
    in_rd     = rd;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] res, input logic c, input logic [3:0] rd);
    drive(op, res, c, rd);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_flags"}, {29'd0, flag_z, flag_c, flag_cmp}, 32'd0);
    check({tag, "_illegal"}, 32'(illegal_cnt), 32'd0);
    check({tag, "_fwd_hit"}, 32'(fwd_hit), 32'd0);
    check({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_result = '0;
    in_carry = 1'b0; in_rd = '0; wb_ready = 1'b0; fwd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single add with carry, committed immediately
    wb_ready = 1'b1;
    push(4'b0000, 32'hFFFF_FFFF, 1'b1, 4'd3);
    #1;
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_wb_addr", 32'(wb_addr), 32'd3);
    check("t1_wb_data", wb_data, 32'hFFFF_FFFF);
    tick();
    check("t1_flag_c", 32'(flag_c), 32'd1);
    check("t1_flag_z", 32'(flag_z), 32'd0);
    check("t1_empty", 32'(wb_valid), 32'd0);

    // Fill to full with write-back stalled
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(4'b0100, 32'(i * 32'h11), 1'b0, 4'(i));
    #1;
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    push(4'b0100, 32'h55, 1'b0, 4'd5);
    #1;
    check("t2_no_fifth", 32'(count), 32'd4);
    wb_ready = 1'b1;
    #1;
    check("t2_head0", wb_data, 32'h11);
    check("t2_ready_before_pop", 32'(in_ready), 32'd0);
    tick();
    check("t2_ready_after_pop", 32'(in_ready), 32'd1);
    check("t2_count3", 32'(count), 32'd3);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("t2_order%0d", i), wb_data, 32'(i * 32'h11));
      check($sformatf("t2_addr%0d", i), 32'(wb_addr), 32'(i));
      tick();
    end
    check("t2_drained", 32'(count), 32'd0);
    check("t2_flag_c_held", 32'(flag_c), 32'd1);

    // Forwarding youngest match; cmp/z/c flag rules
    wb_ready = 1'b0;
    push(4'b0110, 32'd1, 1'b0, 4'd5);
    push(4'b0001, 32'd0, 1'b0, 4'd5);
    fwd_addr = 4'd5;
    #1;
    check("t3_fwd_hit", 32'(fwd_hit), 32'd1);
    check("t3_fwd_young", fwd_data, 32'd0);
    fwd_addr = 4'd6;
    #1;
    check("t3_fwd_miss", 32'(fwd_hit), 32'd0);
    check("t3_fwd_miss_data", fwd_data, 32'd0);
    wb_ready = 1'b1;
    tick();
    check("t3_cmp_set", 32'(flag_cmp), 32'd1);
    check("t3_z_eq", 32'(flag_z), 32'd0);
    tick();
    check("t3_z_sub", 32'(flag_z), 32'd1);
    check("t3_cmp_held", 32'(flag_cmp), 32'd1);
    check("t3_c_held", 32'(flag_c), 32'd1);

    // An entry committing this cycle still forwards
    push(4'b0000, 32'h77, 1'b0, 4'd9);
    fwd_addr = 4'd9;
    #1;
    check("t3b_commit_hit", 32'(fwd_hit), 32'd1);
    check("t3b_commit_data", fwd_data, 32'h77);
    tick();
    check("t3b_after_commit", 32'(fwd_hit), 32'd0);
    check("t3b_flag_c", 32'(flag_c), 32'd0);

    // Illegal opcodes: counted, never pushed, saturating
    drive(4'b1100, 32'hDEAD, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t4_wb_valid%0d", i), 32'(wb_valid), 32'd0);
      check($sformatf("t4_ready%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("t4_illegal3", 32'(illegal_cnt), 32'd3);
    check("t4_count0", 32'(count), 32'd0);
    in_valid = 1'b1;
    repeat (256) tick();
    in_valid = 1'b0;
    #1;
    check("t4_saturate", 32'(illegal_cnt), 32'd255);
    check("t4_never_valid", 32'(wb_valid), 32'd0);

    // Steady push+pop at count 2 preserves order
    wb_ready = 1'b0;
    push(4'b0001, 32'hA0, 1'b0, 4'd1);
    push(4'b0001, 32'hB0, 1'b0, 4'd1);
    q = {32'hA0, 32'hB0};
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 32'hC0 + 32'(i), 1'b0, 4'd2);
      #1;
      check($sformatf("t5_count%0d", i), 32'(count), 32'd2);
      check($sformatf("t5_data%0d", i), wb_data, q[0]);
      tick();
      void'(q.pop_front());
      q.push_back(32'hC0 + 32'(i));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t5_drain%0d", i), wb_data, q[0]);
      tick();
      void'(q.pop_front());
    end
    check("t5_empty", 32'(count), 32'd0);

    // Asynchronous reset mid-stream discards everything
    wb_ready = 1'b0;
    push(4'b0000, 32'h1234, 1'b1, 4'd7);
    push(4'b0110, 32'h1, 1'b0, 4'd8);
    wb_ready = 1'b1;
    tick();
    fwd_addr = 4'd8;
    rst_n = 1'b0;
    #1;
    check_reset_state("t6");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_no_stale%0d", i), 32'(wb_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
